// File: rtl/trng_pkg.sv
// Shared types and defaults for the ring-oscillator entropy harvester.
package trng_pkg;

    typedef enum logic [0:0] {
        PAIR_IDLE       = 1'b0,
        PAIR_HAVE_FIRST = 1'b1
    } pair_state_e;

    localparam int DROP_W        = 8;
    localparam int DEF_N         = 10;
    localparam int DEF_W         = 8;
    localparam int DEF_DIV       = 4;
    localparam int DEF_REP_LIMIT = 32;

endpackage

// File: rtl/trng_vn_debias.sv
// Von Neumann corrector: consumes raw samples in pairs and emits the first
// bit of every unequal pair; equal pairs are discarded.
module trng_vn_debias
    import trng_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_strobe,
    input  logic i_raw_bit,
    input  logic i_hold,
    input  logic i_clr,
    output logic o_bit_valid,
    output logic o_bit_out
);

    pair_state_e r_state;
    logic        r_first;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= PAIR_IDLE;
            r_first <= 1'b0;
        end else if (i_clr || i_hold) begin
            r_state <= PAIR_IDLE;
        end else if (i_strobe) begin
            if (r_state == PAIR_IDLE) begin
                r_state <= PAIR_HAVE_FIRST;
                r_first <= i_raw_bit;
            end else begin
                r_state <= PAIR_IDLE;
            end
        end
    end

    // Pair 10 yields 1 and pair 01 yields 0, i.e. the first bit of the pair.
    assign o_bit_valid = i_strobe && !i_clr && !i_hold &&
                         (r_state == PAIR_HAVE_FIRST) && (r_first != i_raw_bit);
    assign o_bit_out   = r_first;

endmodule

// File: rtl/trng_harvest.sv
// Harvests RO entropy: synchronise, XOR-reduce, sample, debias, pack into
// words on a valid/ready port, with a repetition-count health alarm.
module trng_harvest
    import trng_pkg::*;
#(
    parameter int N         = DEF_N,
    parameter int W         = DEF_W,
    parameter int DIV       = DEF_DIV,
    parameter int REP_LIMIT = DEF_REP_LIMIT
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic              EN,
    input  logic [N-1:0]      RO_IN,
    input  logic              RND_READY,
    output logic [W-1:0]      RND_DATA,
    output logic              RND_VALID,
    output logic              ALARM,
    output logic [DROP_W-1:0] DROP_CNT
);

    localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BCNT_W = $clog2(W + 1);
    localparam int REP_W  = $clog2(REP_LIMIT + 1);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(W - 1);
    localparam logic [REP_W-1:0]  REP_MAX   = REP_W'(REP_LIMIT);

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (&v) ? v : v + DROP_W'(1);
    endfunction

    logic [N-1:0]      r_sync_p0;
    logic [N-1:0]      r_sync_p1;
    logic              r_raw_p2;
    logic [DIV_W-1:0]  r_div;
    logic [REP_W-1:0]  r_rep_cnt;
    logic              r_prev;
    logic              r_alarm;
    logic [W-1:0]      r_shreg;
    logic [BCNT_W-1:0] r_bcnt;
    logic [W-1:0]      r_data;
    logic              r_valid;
    logic [DROP_W-1:0] r_drop_cnt;

    logic              w_strobe;
    logic [REP_W-1:0]  w_rep_next;
    logic              w_bit_valid;
    logic              w_bit;
    logic [W-1:0]      w_word;
    logic              w_complete;
    logic              w_xfer;
    logic              w_load;
    logic              w_drop;

    // Two-flop synchroniser per RO line, then a registered XOR-reduce.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_sync_p0 <= '0;
            r_sync_p1 <= '0;
            r_raw_p2  <= 1'b0;
        end else begin
            r_sync_p0 <= RO_IN;
            r_sync_p1 <= r_sync_p0;
            r_raw_p2  <= ^r_sync_p1;
        end
    end

    assign w_strobe = EN && (r_div == DIV_LAST);

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_div <= '0;
        end else if (!EN || w_strobe) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    // A count of zero means no previous sample since reset or disable.
    always_comb begin
        w_rep_next = r_rep_cnt;
        if ((r_rep_cnt == '0) || (r_raw_p2 != r_prev)) begin
            w_rep_next = REP_W'(1);
        end else if (r_rep_cnt != REP_MAX) begin
            w_rep_next = r_rep_cnt + REP_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_rep_cnt <= '0;
            r_prev    <= 1'b0;
            r_alarm   <= 1'b0;
        end else if (!EN) begin
            r_rep_cnt <= '0;
            r_prev    <= 1'b0;
        end else if (w_strobe) begin
            r_rep_cnt <= w_rep_next;
            r_prev    <= r_raw_p2;
            if (w_rep_next == REP_MAX) begin
                r_alarm <= 1'b1;
            end
        end
    end

    trng_vn_debias u_debias (
        .i_clk       (CLK),
        .i_rst_n     (RST_n),
        .i_strobe    (w_strobe),
        .i_raw_bit   (r_raw_p2),
        .i_hold      (r_alarm),
        .i_clr       (!EN),
        .o_bit_valid (w_bit_valid),
        .o_bit_out   (w_bit)
    );

    assign w_word     = {r_shreg[W-2:0], w_bit};
    assign w_complete = w_bit_valid && (r_bcnt == BCNT_LAST);
    assign w_xfer     = r_valid && RND_READY;
    assign w_load     = w_complete && (!r_valid || RND_READY);
    assign w_drop     = w_complete && !w_load;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_shreg <= '0;
            r_bcnt  <= '0;
        end else if (!EN) begin
            r_shreg <= '0;
            r_bcnt  <= '0;
        end else if (w_bit_valid) begin
            r_shreg <= w_word;
            r_bcnt  <= w_complete ? '0 : r_bcnt + BCNT_W'(1);
        end
    end

    // Single-entry output slot; a completed word is lost only if the slot
    // is occupied and not being drained on the same edge.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (w_load) begin
                r_data  <= w_word;
                r_valid <= 1'b1;
            end else if (w_xfer) begin
                r_valid <= 1'b0;
            end
            if (w_drop) begin
                r_drop_cnt <= sat_inc(r_drop_cnt);
            end
        end
    end

    assign RND_DATA  = r_data;
    assign RND_VALID = r_valid;
    assign ALARM     = r_alarm;
    assign DROP_CNT  = r_drop_cnt;

endmodule

// File: doc/trng_harvest.md
Name: trng_harvest

Overview:
Downstream consumer of the ring-oscillator TRNG bank.
- Synchronises the N raw RO outputs into CLK and XOR-reduces them to one raw bit.
- Samples that bit every DIV cycles and removes bias with a von Neumann corrector.
- Packs the debiased bits into W-bit words and presents them on a valid/ready port, feeding the LED/SPI export logic.
- Runs a repetition-count health test on the raw samples and raises a sticky alarm on a stuck source.

Parameters:
N, 10, number of RO inputs (width of RO_IN)
W, 8, output word width in bits
DIV, 4, sample period in CLK cycles (>=1)
REP_LIMIT, 32, consecutive identical raw samples that trigger ALARM (>=2)

Ports:
CLK  input  1  system clock (CLK_50 domain)
RST_n  input  1  asynchronous active-low reset
EN  input  1  harvest enable
RO_IN  input  N  asynchronous RO outputs from the TRNG bank
RND_READY  input  1  consumer accepts word
RND_DATA  output  W  random word
RND_VALID  output  1  RND_DATA holds an unconsumed word
ALARM  output  1  sticky health-test failure
DROP_CNT  output  8  saturating count of words lost to backpressure

Behaviour:
- Reset and clock: one clock, CLK. Reset is asynchronous and active-low on RST_n. While RST_n=0, every flop clears: synchroniser, sample counter, pair FSM, assembler, RND_DATA=0, RND_VALID=0, ALARM=0, DROP_CNT=0. Reset may be asserted mid-word; the partial word is discarded.
- Synchroniser: two flops per RO_IN bit, then a registered XOR-reduce to raw_bit. Latency from RO_IN to raw_bit is 3 cycles.
- Sample strobe: div counter runs 0..DIV-1 while EN=1; strobe fires when count==DIV-1. With DIV=1 the strobe fires every cycle. EN=0 holds the counter at 0.
- Pair FSM (states IDLE, HAVE_FIRST), advancing only on strobe:
  - IDLE: store raw_bit as first, go to HAVE_FIRST.
  - HAVE_FIRST, first!=raw_bit: emit first (pair 10 gives 1, pair 01 gives 0), go to IDLE.
  - HAVE_FIRST, first==raw_bit: discard, go to IDLE.
- Assembler:
  - Each emitted bit shifts in at LSB (shreg <= {shreg[W-2:0], bit}) on the same edge as the second strobe; bit count increments.
  - On the edge where the count reaches W: if RND_VALID=0, or RND_VALID&&RND_READY in that cycle, the word loads into RND_DATA; RND_VALID=1 from the next cycle.
  - Otherwise the word is dropped and DROP_CNT increments, saturating at 255.
  - Either way the count returns to 0.
- Output handshake:
  - Transfer occurs when RND_VALID&&RND_READY.
  - Transfer without a load: RND_VALID=0 next cycle.
  - Transfer and load in the same cycle: RND_VALID stays 1 and RND_DATA takes the new word.
  - RND_DATA is stable while RND_VALID&&!RND_READY.
- Health test:
  - On every strobe, rep_cnt resets to 1 if raw_bit differs from the previous sample, else increments.
  - When rep_cnt reaches REP_LIMIT, ALARM=1 on that edge.
  - ALARM is sticky and clears only on reset.
  - While ALARM=1 the pair FSM is held in IDLE and no bits are emitted. A word already in RND_DATA may still drain.
- EN=0 (any cycle):
  - Clears the pair FSM to IDLE, the assembler count and shreg, and rep_cnt/previous sample.
  - Does not touch RND_DATA, RND_VALID, ALARM or DROP_CNT. A pending word still drains.
  - The synchroniser keeps running.

Decomposition:
- Package trng_pkg holds:
  - the pair-FSM state enum (IDLE, HAVE_FIRST);
  - the DROP_CNT width constant (8);
  - the default values for N, W, DIV and REP_LIMIT.
- One sub-module, trng_vn_debias, contains the pair FSM. Interface: strobe, raw_bit, hold, clr; outputs bit_valid, bit_out.
- Synchroniser, strobe counter, assembler, handshake and health test stay in trng_harvest.

Test Plan:
1. All tests use N=10, W=8, DIV=1, REP_LIMIT=32. The bench drives RO_IN[0] synchronously with the other inputs at 0; RND_READY=1 unless stated.
2. Debias: sample pairs 10,01,10,10,01,01,10,01, with pairs 00 and 11 interleaved -> exactly one word, RND_DATA=8'hB2. RND_VALID rises one cycle after the 16th useful sample; 00/11 pairs add no bits.
3. Backpressure: RND_READY=0 while two words are assembled -> first word held stable with RND_VALID=1, second dropped, DROP_CNT=1. Then RND_READY=1 for one cycle -> RND_VALID=0 next cycle.
4. Simultaneous: RND_READY=1 in the cycle the next word completes while RND_VALID=1 -> RND_VALID stays 1 and RND_DATA updates to the new word.
5. Health and EN:
   - RO_IN constant 0 -> ALARM=1 at the 32nd identical sample. It stays 1 after RO_IN toggles; no further words are produced until RST_n pulses low.
   - Separately, EN=0 after 5 debiased bits, then EN=1 -> the next word contains only the 8 post-enable bits.
6. Async reset: RST_n=0 mid-word with RND_VALID=1 and DROP_CNT=3 -> RND_VALID, RND_DATA and DROP_CNT go to 0 without a clock edge. After release, the first word needs 8 fresh bits.
